// File: rtl/mem_port_arb_pkg.sv
// mem_port_arb_pkg: shared sizes for the scratch-memory port arbiter.
//   AddrW  - word address width of the 4096x24 scratch memory
//   DataW  - data width of the scratch memory
//   MaxReq - largest supported requester count
// The size macros normally come from the project-wide sizes header; the guarded
// defaults below keep this slice self-contained when that header is absent.

`ifndef HBIT_ADDR
`define HBIT_ADDR 11
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef MEMARB_MAX_REQ
`define MEMARB_MAX_REQ 8
`endif

package mem_port_arb_pkg;

  localparam int unsigned AddrW  = `HBIT_ADDR + 1;
  localparam int unsigned DataW  = `HBIT_DATA + 1;
  localparam int unsigned MaxReq = `MEMARB_MAX_REQ;

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational round-robin picker.
//   req  - request vector, bit i = requester i
//   last - index granted most recently; the scan starts just after it
//   gnt  - one-hot grant (all zero when nothing requests)
//   any  - at least one grant issued

module arb_rr_pick #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] last,
  output logic [N-1:0]    gnt,
  output logic            any
);

  logic [IdxW-1:0] idx;

  // Scan last+1 .. last+N modulo N; the first requester found wins.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IdxW'((32'(last) + k) % N);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one scratch-memory port between NUM_REQ requesters.
//   iw_clk, iw_rst_n       - clock, asynchronous active-low reset
//   iw_req/we/addr/wdata   - per-requester access request (held until granted)
//   ow_gnt                 - combinational one-hot grant; access happens this cycle
//   or_rvalid              - registered pulse the cycle after a granted read
//   ow_rdata               - read data, passed through from iw_mem_rdata
//   ow_mem_we/addr/wdata   - memory port drive (zero when idle)
//   iw_mem_rdata           - registered read data from the memory
// Policy: starvation override, then optional requester-0 priority, then round-robin.

module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned PRIO0    = 1,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic             iw_clk,
  input  logic             iw_rst_n,
  input  logic             iw_req    [0:NUM_REQ-1],
  input  logic             iw_we     [0:NUM_REQ-1],
  input  logic [AddrW-1:0] iw_addr   [0:NUM_REQ-1],
  input  logic [DataW-1:0] iw_wdata  [0:NUM_REQ-1],
  output logic             ow_gnt    [0:NUM_REQ-1],
  output logic             or_rvalid [0:NUM_REQ-1],
  output logic [DataW-1:0] ow_rdata,
  output logic             ow_mem_we,
  output logic [AddrW-1:0] ow_mem_addr,
  output logic [DataW-1:0] ow_mem_wdata,
  input  logic [DataW-1:0] iw_mem_rdata
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  if (NUM_REQ < 2 || NUM_REQ > MaxReq) begin : g_bad_num_req
    $error("mem_port_arb: NUM_REQ out of range");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("mem_port_arb: MAX_WAIT out of range");
  end

  logic [NUM_REQ-1:0] req_v;
  logic [NUM_REQ-1:0] rr_gnt;
  logic               rr_any;
  logic [IdxW-1:0]    rr_idx;
  logic               ovr;
  logic [IdxW-1:0]    ovr_idx;
  logic               gnt_any;
  logic [IdxW-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [IdxW-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [WaitW-1:0]   wait_q [NUM_REQ];
  logic [WaitW-1:0]   wait_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_v[i] = iw_req[i];
  end

  arb_rr_pick #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req  (req_v),
    .last (last_q),
    .gnt  (rr_gnt),
    .any  (rr_any)
  );

  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_gnt[i]) rr_idx = IdxW'(i);
    end
  end

  // Descending scan so the lowest starved index ends up selected.
  always_comb begin
    ovr     = 1'b0;
    ovr_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_v[i] && wait_q[i] == WaitW'(MAX_WAIT)) begin
        ovr     = 1'b1;
        ovr_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (ovr) begin
      gnt_any = 1'b1;
      gnt_idx = ovr_idx;
    end else if (PRIO0 != 0 && req_v[0]) begin
      gnt_any = 1'b1;
      gnt_idx = '0;
    end else if (rr_any) begin
      gnt_any = 1'b1;
      gnt_idx = rr_idx;
    end
    // No access may leak onto the memory port while reset is held.
    if (!iw_rst_n) gnt_any = 1'b0;
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ow_mem_we    = 1'b0;
    ow_mem_addr  = '0;
    ow_mem_wdata = '0;
    if (gnt_any) begin
      ow_mem_we    = iw_we[gnt_idx];
      ow_mem_addr  = iw_addr[gnt_idx];
      ow_mem_wdata = iw_wdata[gnt_idx];
    end
  end

  always_comb begin
    last_d = gnt_any ? gnt_idx : last_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid_d[i] = gnt[i] && !iw_we[i];
      if (req_v[i] && !gnt[i]) begin
        wait_d[i] = (wait_q[i] == WaitW'(MAX_WAIT)) ? wait_q[i] : wait_q[i] + 1'b1;
      end else begin
        wait_d[i] = '0;
      end
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      last_q   <= IdxW'(NUM_REQ - 1);
      rvalid_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else begin
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ow_gnt[i]    = gnt[i];
      or_rvalid[i] = rvalid_q[i];
    end
  end

  assign ow_rdata = iw_mem_rdata;

endmodule
